// File: rtl/cgra_clock_gate_ctrl_if.sv
// ----------------------------------------------------------------------------
// cgra_clock_gate_ctrl_if
// Bundle of all per-domain control, handshake and clock signals exchanged
// between the clock-gating controller and its environment (software
// registers plus the gated CGRA domains).
//
//   master : environment side (drives enables, busy/wake, stop acknowledge,
//            test override, statistics clear; observes everything else)
//   slave  : controller side (cgra_clock_gate_ctrl)
//
// Signals (N = N_DOMAINS):
//   test_en_i   1            scan/test override, all gated clocks run
//   sw_en_i     N            software enable per domain
//   auto_en_i   N            allow idle auto-gating per domain
//   idle_thr_i  IDLE_CNT_W   idle cycles before auto-gating (0 = off)
//   busy_i      N            domain activity
//   wake_i      N            wake request for an auto-slept domain
//   stop_ack_i  N            domain drained and safe to stop
//   clr_stats_i 1            clear gated-cycle statistics
//   stop_req_o  N            drain request
//   clk_o       N            gated clocks
//   gate_en_o   N            registered clock-gate enables
//   state_o     2*N          per-domain state (OFF=0 RUN=1 DRAIN=2 SLEEP=3)
//   gated_cnt_o STAT_W*N     gated-cycle counters
// ----------------------------------------------------------------------------
interface cgra_clock_gate_ctrl_if #(
    parameter int unsigned N_DOMAINS  = 4,
    parameter int unsigned IDLE_CNT_W = 8,
    parameter int unsigned STAT_W     = 32
);
    logic                          test_en_i;
    logic [N_DOMAINS-1:0]          sw_en_i;
    logic [N_DOMAINS-1:0]          auto_en_i;
    logic [IDLE_CNT_W-1:0]         idle_thr_i;
    logic [N_DOMAINS-1:0]          busy_i;
    logic [N_DOMAINS-1:0]          wake_i;
    logic [N_DOMAINS-1:0]          stop_ack_i;
    logic                          clr_stats_i;
    logic [N_DOMAINS-1:0]          stop_req_o;
    logic [N_DOMAINS-1:0]          clk_o;
    logic [N_DOMAINS-1:0]          gate_en_o;
    logic [2*N_DOMAINS-1:0]        state_o;
    logic [STAT_W*N_DOMAINS-1:0]   gated_cnt_o;

    modport master (
        output test_en_i, sw_en_i, auto_en_i, idle_thr_i, busy_i, wake_i,
               stop_ack_i, clr_stats_i,
        input  stop_req_o, clk_o, gate_en_o, state_o, gated_cnt_o
    );

    modport slave (
        input  test_en_i, sw_en_i, auto_en_i, idle_thr_i, busy_i, wake_i,
               stop_ack_i, clr_stats_i,
        output stop_req_o, clk_o, gate_en_o, state_o, gated_cnt_o
    );
endinterface

// File: rtl/cgra_clock_gate_ctrl.sv
// ----------------------------------------------------------------------------
// cgra_clock_gate_ctrl
// Multi-domain clock-gating controller for the CGRA subsystem. Each domain
// has its own FSM (OFF / RUN / DRAIN / SLEEP) combining a software enable
// with automatic idle gating. A stop request/acknowledge handshake drains a
// domain before its clock is stopped; wake/busy restore it.
//
// Ports:
//   clk_i  system clock
//   rst_i  asynchronous active-high reset
//   bus    cgra_clock_gate_ctrl_if.slave (enables, handshake, gated clocks,
//          state, statistics)
//
// Optional feature: define CGRA_CG_STATS_EN to build per-domain saturating
// gated-cycle counters (cleared by clr_stats_i). Without it gated_cnt_o is
// tied to zero and clr_stats_i is ignored.
//
// Also contains cgra_clock_gate, the glitch-free gate used per domain.
// ----------------------------------------------------------------------------

// Glitch-free clock gate: the enable is captured on the falling edge, so it
// can only change while clk_i is low and clk_o never produces a runt pulse.
module cgra_clock_gate (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    input  logic test_en_i,
    output logic clk_o
);
    logic en_q;

    always_ff @(negedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            en_q <= 1'b0;
        end else begin
            en_q <= en_i | test_en_i;
        end
    end

    assign clk_o = clk_i & en_q;
endmodule

module cgra_clock_gate_ctrl #(
    parameter int unsigned N_DOMAINS  = 4,
    parameter int unsigned IDLE_CNT_W = 8,
    parameter int unsigned STAT_W     = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    cgra_clock_gate_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_SLEEP = 2'd3
    } dom_state_e;

    localparam logic [IDLE_CNT_W-1:0] IDLE_MAX = '1;

`ifndef CGRA_CG_STATS_EN
    logic unused_clr_stats;
    assign unused_clr_stats = bus.clr_stats_i;
`endif

    for (genvar d = 0; d < N_DOMAINS; d++) begin : g_dom
        dom_state_e            state_q, state_d;
        logic                  reason_auto_q, reason_auto_d;
        logic [IDLE_CNT_W-1:0] idle_cnt_q, idle_cnt_d;
        logic                  idle_cycle;
        logic                  idle_expired;
        logic                  gate_en;
        logic                  stop_req;
        logic                  gclk;

        // State register
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                state_q       <= ST_OFF;
                reason_auto_q <= 1'b0;
                idle_cnt_q    <= '0;
            end else begin
                state_q       <= state_d;
                reason_auto_q <= reason_auto_d;
                idle_cnt_q    <= idle_cnt_d;
            end
        end

        // Next-state logic
        always_comb begin
            state_d       = state_q;
            reason_auto_d = reason_auto_q;
            idle_cnt_d    = '0;
            idle_cycle    = !bus.busy_i[d] && !bus.wake_i[d] &&
                            bus.auto_en_i[d] && (bus.idle_thr_i != '0);
            // >= rather than == so a threshold lowered below the running
            // count still fires on the next idle cycle.
            idle_expired  = idle_cycle &&
                            (idle_cnt_q >= bus.idle_thr_i - IDLE_CNT_W'(1));

            case (state_q)
                ST_OFF: begin
                    if (bus.sw_en_i[d]) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (bus.busy_i[d] || bus.wake_i[d]) begin
                        idle_cnt_d = '0;
                    end else if (idle_cycle) begin
                        idle_cnt_d = (idle_cnt_q == IDLE_MAX) ? idle_cnt_q
                                   : idle_cnt_q + IDLE_CNT_W'(1);
                    end else begin
                        idle_cnt_d = idle_cnt_q;
                    end

                    if (!bus.sw_en_i[d]) begin
                        state_d       = ST_DRAIN;
                        reason_auto_d = 1'b0;
                        idle_cnt_d    = '0;
                    end else if (idle_expired) begin
                        state_d       = ST_DRAIN;
                        reason_auto_d = 1'b1;
                        idle_cnt_d    = '0;
                    end
                end
                ST_DRAIN: begin
                    // Software disable outranks everything: it turns an auto
                    // drain into a software drain without restarting it.
                    if (!bus.sw_en_i[d]) begin
                        reason_auto_d = 1'b0;
                        if (bus.stop_ack_i[d]) begin
                            state_d = ST_OFF;
                        end
                    end else if (reason_auto_q &&
                                 (bus.busy_i[d] || bus.wake_i[d])) begin
                        state_d = ST_RUN;
                    end else if (bus.stop_ack_i[d]) begin
                        state_d = reason_auto_q ? ST_SLEEP : ST_OFF;
                    end
                end
                ST_SLEEP: begin
                    if (!bus.sw_en_i[d]) begin
                        state_d = ST_OFF;
                    end else if (bus.wake_i[d] || !bus.auto_en_i[d]) begin
                        state_d = ST_RUN;
                    end
                end
                default: begin
                    state_d = ST_OFF;
                end
            endcase
        end

        // Output decode (straight from the state register, so registered)
        always_comb begin
            gate_en  = (state_q == ST_RUN) || (state_q == ST_DRAIN);
            stop_req = (state_q == ST_DRAIN);
        end

        cgra_clock_gate u_gate (
            .clk_i     (clk_i),
            .rst_i     (rst_i),
            .en_i      (gate_en),
            .test_en_i (bus.test_en_i),
            .clk_o     (gclk)
        );

        assign bus.clk_o[d]          = gclk;
        assign bus.gate_en_o[d]      = gate_en;
        assign bus.stop_req_o[d]     = stop_req;
        assign bus.state_o[2*d +: 2] = state_q;

`ifdef CGRA_CG_STATS_EN
        logic [STAT_W-1:0] stat_q;

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                stat_q <= '0;
            end else if (bus.clr_stats_i) begin
                stat_q <= '0;
            end else if (!gate_en && (stat_q != '1)) begin
                stat_q <= stat_q + STAT_W'(1);
            end
        end

        assign bus.gated_cnt_o[STAT_W*d +: STAT_W] = stat_q;
`else
        assign bus.gated_cnt_o[STAT_W*d +: STAT_W] = '0;
`endif
    end
endmodule
